// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_KEEP,
        PC_SEQ,
        PC_BR,
        PC_RST
    } pc_op_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_INC    = 4;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load, hold and flush-to-bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               hold,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr,
    input  logic [ADDR_W-1:0]  pc_plus4,
    output logic [INSTR_W-1:0] InstrD,
    output logic [ADDR_W-1:0]  PCPlus4D,
    output logic               ValidD
);

    // A bubble keeps PCPlus4D; only InstrD and ValidD are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= INSTR_W'(NOP_INSTR);
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (flush || (!hold && !load)) begin
            InstrD <= INSTR_W'(NOP_INSTR);
            ValidD <= 1'b0;
        end else if (!hold) begin
            InstrD   <= instr;
            PCPlus4D <= pc_plus4;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PCF, imem req/ack port, skid buffer, IF/ID.
// Optional DELAY_SLOT_EN keeps the sequential slot on a taken branch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               PCSrcD,
    input  logic [ADDR_W-1:0]  PCBranchD,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] InstrD,
    output logic [ADDR_W-1:0]  PCPlus4D,
    output logic               ValidD,
    output logic               FetchBusy
);

    fetch_state_t       state, state_nx;
    pc_op_t             pc_op;
    logic [ADDR_W-1:0]  pcf, pc_inc, seq_pc, pend_addr;
    logic [INSTR_W-1:0] buf_instr, ifid_instr;
    logic               redir, ifid_load, ifid_flush, ifid_from_buf;
    logic               buf_load, pend_load;

    assign redir  = PCSrcD & ~StallD;
    assign pc_inc = pcf + ADDR_W'(PC_INC);

`ifdef DELAY_SLOT_EN
    // Redirect taken while the slot fetch is still outstanding.
    logic              rp_set, redir_pend;
    logic [ADDR_W-1:0] redir_tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_pend <= 1'b0;
            redir_tgt  <= RESET_PC;
        end else if (rp_set) begin
            redir_pend <= 1'b1;
            redir_tgt  <= PCBranchD;
        end else if (pc_op != PC_KEEP) begin
            redir_pend <= 1'b0;
        end
    end

    assign seq_pc = redir_pend ? redir_tgt : pc_inc;
`else
    assign seq_pc = pc_inc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!inicio) state_nx = FETCH;
            end
            FETCH: begin
                if (inicio) begin
                    state_nx = imem_ack ? IDLE : DRAIN;
                end else if (redir) begin
`ifdef DELAY_SLOT_EN
                    state_nx = FETCH;
`else
                    state_nx = imem_ack ? FETCH : DRAIN;
`endif
                end else if (imem_ack && StallF) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (inicio)                 state_nx = IDLE;
                else if (redir)             state_nx = FETCH;
                else if (!StallF && !StallD) state_nx = FETCH;
            end
            DRAIN: begin
                if (imem_ack) state_nx = inicio ? IDLE : FETCH;
            end
        endcase
    end

    always_comb begin
        imem_req      = (state == FETCH) || (state == DRAIN);
        imem_addr     = (state == DRAIN) ? pend_addr : pcf;
        FetchBusy     = imem_req & ~imem_ack;
        pc_op         = PC_KEEP;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_from_buf = 1'b0;
        buf_load      = 1'b0;
        pend_load     = 1'b0;
`ifdef DELAY_SLOT_EN
        rp_set        = 1'b0;
`endif
        if (inicio) begin
            pc_op      = PC_RST;
            ifid_flush = 1'b1;
            pend_load  = (state == FETCH) && !imem_ack;
        end else begin
            unique case (state)
                IDLE, DRAIN: begin
                    if (redir) begin
                        pc_op      = PC_BR;
                        ifid_flush = 1'b1;
                    end
                end
                FETCH: begin
                    if (redir) begin
`ifdef DELAY_SLOT_EN
                        if (imem_ack) begin
                            pc_op     = PC_BR;
                            ifid_load = 1'b1;
                        end else begin
                            rp_set = 1'b1;
                        end
`else
                        pc_op      = PC_BR;
                        ifid_flush = 1'b1;
                        pend_load  = ~imem_ack;
`endif
                    end else if (imem_ack) begin
                        if (StallF) begin
                            buf_load = 1'b1;
                        end else begin
                            pc_op     = PC_SEQ;
                            ifid_load = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (redir) begin
                        pc_op = PC_BR;
`ifdef DELAY_SLOT_EN
                        ifid_load     = 1'b1;
                        ifid_from_buf = 1'b1;
`else
                        ifid_flush = 1'b1;
`endif
                    end else if (!StallF && !StallD) begin
                        pc_op         = PC_SEQ;
                        ifid_load     = 1'b1;
                        ifid_from_buf = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf       <= RESET_PC;
            pend_addr <= RESET_PC;
            buf_instr <= INSTR_W'(NOP_INSTR);
        end else begin
            unique case (pc_op)
                PC_KEEP: pcf <= pcf;
                PC_SEQ:  pcf <= seq_pc;
                PC_BR:   pcf <= PCBranchD;
                PC_RST:  pcf <= RESET_PC;
            endcase
            if (pend_load) pend_addr <= pcf;
            if (buf_load)  buf_instr <= imem_rdata;
        end
    end

    assign ifid_instr = ifid_from_buf ? buf_instr : imem_rdata;

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ifid_load),
        .hold     (StallD),
        .flush    (ifid_flush),
        .instr    (ifid_instr),
        .pc_plus4 (pc_inc),
        .InstrD   (InstrD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

endmodule
